// File: rtl/ula_pkg.sv
// Shared types and ula_8_bits function codes for the byte-serial ALU sequencer.
package ula_pkg;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} seq_state_t;

    localparam logic [3:0] ULA_S_XOR = 4'b0110;
    localparam logic [3:0] ULA_S_ADD = 4'b1001;
    localparam logic [3:0] ULA_S_AND = 4'b1011;
    localparam logic [3:0] ULA_S_OR  = 4'b1110;

    localparam logic ULA_M_LOGIC = 1'b1;
    localparam logic ULA_M_ARITH = 1'b0;

endpackage

// File: rtl/ula_op_sequencer.sv
// Drives an external ula_8_bits one byte per cycle, LSB first, chaining carry and
// accumulating the wide result plus equality flag behind two valid/ready handshakes.
module ula_op_sequencer #(
    parameter int unsigned BYTES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*BYTES-1:0]   in_a,
    input  logic [8*BYTES-1:0]   in_b,
    input  logic [3:0]           in_s,
    input  logic                 in_m,
    input  logic                 in_c_in,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [3:0]           alu_s,
    output logic                 alu_m,
    output logic                 alu_c_in,
    input  logic [7:0]           alu_f,
    input  logic                 alu_a_eq_b,
    input  logic                 alu_c_out,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [8*BYTES-1:0]   res_f,
    output logic                 res_c_out,
    output logic                 res_a_eq_b,
    output logic                 busy
);
    import ula_pkg::*;

    localparam int unsigned W  = 8 * BYTES;
    localparam int unsigned IW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

    seq_state_t     state, state_nxt;
    logic [W-1:0]   a_reg, b_reg, res_reg;
    logic [3:0]     s_reg;
    logic           m_reg;
    logic           carry_reg;
    logic           eq_reg;
    logic [IW-1:0]  idx;
    logic [IW+2:0]  bit_off;

    assign bit_off = {idx, 3'b000};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        alu_a     = '0;
        alu_b     = '0;
        alu_c_in  = 1'b0;
        alu_s     = s_reg;
        alu_m     = m_reg;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = EXEC;
            end
            EXEC: begin
                alu_a    = a_reg[bit_off +: 8];
                alu_b    = b_reg[bit_off +: 8];
                alu_c_in = carry_reg;
                if (idx == LAST_IDX) state_nxt = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // idx wraps to 0 on the last byte so it never points past the operand outside EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            s_reg     <= '0;
            m_reg     <= 1'b0;
            carry_reg <= 1'b0;
            eq_reg    <= 1'b1;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= in_a;
                        b_reg     <= in_b;
                        s_reg     <= in_s;
                        m_reg     <= in_m;
                        carry_reg <= in_c_in;
                        eq_reg    <= 1'b1;
                        idx       <= '0;
                    end
                end
                EXEC: begin
                    res_reg[bit_off +: 8] <= alu_f;
                    carry_reg             <= alu_c_out;
                    eq_reg                <= eq_reg & alu_a_eq_b;
                    idx                   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign res_f      = res_reg;
    assign res_c_out  = carry_reg;
    assign res_a_eq_b = eq_reg;

endmodule

// File: tb/tb_ula_op_sequencer.sv
// Directed and back-to-back checks of ula_op_sequencer (BYTES=2) against a small
// behavioural byte ALU standing in for ula_8_bits.
module tb_ula_op_sequencer;
    import ula_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [15:0] in_a, in_b;
    logic [3:0]  in_s;
    logic        in_m, in_c_in;
    logic [7:0]  alu_a, alu_b, alu_f;
    logic [3:0]  alu_s;
    logic        alu_m, alu_c_in, alu_a_eq_b, alu_c_out;
    logic        res_valid, res_ready;
    logic [15:0] res_f;
    logic        res_c_out, res_a_eq_b, busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    ula_op_sequencer #(.BYTES(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_s(in_s), .in_m(in_m), .in_c_in(in_c_in),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_c_in(alu_c_in),
        .alu_f(alu_f), .alu_a_eq_b(alu_a_eq_b), .alu_c_out(alu_c_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_f(res_f), .res_c_out(res_c_out), .res_a_eq_b(res_a_eq_b),
        .busy(busy)
    );

    // Byte ALU model: logic ops give no carry, ADD carries active-high.
    always_comb begin
        alu_f      = '0;
        alu_c_out  = 1'b0;
        alu_a_eq_b = (alu_a == alu_b);
        if (alu_m) begin
            case (alu_s)
                ULA_S_XOR: alu_f = alu_a ^ alu_b;
                ULA_S_AND: alu_f = alu_a & alu_b;
                ULA_S_OR:  alu_f = alu_a | alu_b;
                default:   alu_f = ~alu_a;
            endcase
        end else begin
            case (alu_s)
                ULA_S_ADD: {alu_c_out, alu_f} = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_c_in};
                default:   {alu_c_out, alu_f} = {1'b0, alu_a} + {8'b0, alu_c_in};
            endcase
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                            input logic [3:0] s, input logic m, input logic cin);
        in_a = a; in_b = b; in_s = s; in_m = m; in_c_in = cin;
        in_valid = 1'b1;
        for (int n = 0; n < 20 && !in_ready; n++) tick;
        if (!in_ready) begin
            total_cnt++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        tick;
        in_valid = 1'b0;
    endtask

    task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] s, input logic m, input logic cin,
                         input logic [15:0] ef, input logic ec, input logic ee);
        start_op(a, b, s, m, cin);
        for (int n = 0; n < 10 && !res_valid; n++) tick;
        total_cnt++;
        if (res_f !== ef || res_c_out !== ec || res_a_eq_b !== ee || res_valid !== 1'b1)
            $display("FAIL %s: f=%h c=%b eq=%b v=%b required f=%h c=%b eq=%b v=1",
                     name, res_f, res_c_out, res_a_eq_b, res_valid, ef, ec, ee);
        else pass_cnt++;
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
        in_a = '0; in_b = '0; in_s = '0; in_m = 1'b0; in_c_in = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick;
            total_cnt++;
            if (in_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 ||
                alu_a !== 8'h00 || alu_b !== 8'h00)
                $display("FAIL reset_ctrl: rdy=%b v=%b busy=%b a=%h b=%h required 1 0 0 00 00",
                         in_ready, res_valid, busy, alu_a, alu_b);
            else pass_cnt++;
        end
        total_cnt++;
        if (res_f !== 16'h0000 || res_c_out !== 1'b0 || res_a_eq_b !== 1'b1 ||
            alu_c_in !== 1'b0 || alu_s !== 4'h0 || alu_m !== 1'b0)
            $display("FAIL reset_res: f=%h c=%b eq=%b cin=%b s=%h m=%b required 0000 0 1 0 0 0",
                     res_f, res_c_out, res_a_eq_b, alu_c_in, alu_s, alu_m);
        else pass_cnt++;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_logic;
        start_op(16'h1234, 16'h1234, ULA_S_XOR, ULA_M_LOGIC, 1'b0);
        total_cnt++;
        if (res_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL logic_exec0: v=%b busy=%b rdy=%b required 0 1 0", res_valid, busy, in_ready);
        else pass_cnt++;
        tick;
        total_cnt++;
        if (res_valid !== 1'b0) $display("FAIL logic_exec1: v=%b required 0", res_valid);
        else pass_cnt++;
        tick;
        total_cnt++;
        if (res_valid !== 1'b1 || res_f !== 16'h0000 || res_a_eq_b !== 1'b1 || res_c_out !== 1'b0)
            $display("FAIL logic_xor: v=%b f=%h eq=%b c=%b required 1 0000 1 0",
                     res_valid, res_f, res_a_eq_b, res_c_out);
        else pass_cnt++;
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        total_cnt++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL logic_release: v=%b rdy=%b required 0 1", res_valid, in_ready);
        else pass_cnt++;
        do_op("logic_or",  16'h1234, 16'h00FF, ULA_S_OR,  ULA_M_LOGIC, 1'b1, 16'h12FF, 1'b0, 1'b0);
        do_op("logic_and", 16'hF00F, 16'h3C3C, ULA_S_AND, ULA_M_LOGIC, 1'b0, 16'h300C, 1'b0, 1'b0);
    endtask

    task automatic test_carry;
        start_op(16'h00FF, 16'h0001, ULA_S_ADD, ULA_M_ARITH, 1'b0);
        total_cnt++;
        if (alu_a !== 8'hFF || alu_b !== 8'h01 || alu_c_in !== 1'b0 ||
            alu_s !== ULA_S_ADD || alu_m !== ULA_M_ARITH)
            $display("FAIL carry_byte0: a=%h b=%h cin=%b s=%h m=%b required ff 01 0 9 0",
                     alu_a, alu_b, alu_c_in, alu_s, alu_m);
        else pass_cnt++;
        tick;
        total_cnt++;
        if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_c_in !== 1'b1)
            $display("FAIL carry_byte1: a=%h b=%h cin=%b required 00 00 1", alu_a, alu_b, alu_c_in);
        else pass_cnt++;
        tick;
        total_cnt++;
        if (res_valid !== 1'b1 || res_f !== 16'h0100 || res_c_out !== 1'b0 || res_a_eq_b !== 1'b0)
            $display("FAIL carry_result: v=%b f=%h c=%b eq=%b required 1 0100 0 0",
                     res_valid, res_f, res_c_out, res_a_eq_b);
        else pass_cnt++;
        total_cnt++;
        if (alu_a !== 8'h00 || alu_c_in !== 1'b0 || alu_s !== ULA_S_ADD)
            $display("FAIL carry_idle_alu: a=%h cin=%b s=%h required 00 0 9", alu_a, alu_c_in, alu_s);
        else pass_cnt++;
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        do_op("add_wrap", 16'hFFFF, 16'h0001, ULA_S_ADD, ULA_M_ARITH, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("add_cin",  16'h0000, 16'h0000, ULA_S_ADD, ULA_M_ARITH, 1'b1, 16'h0001, 1'b0, 1'b1);
        do_op("add_msb",  16'h8000, 16'h8000, ULA_S_ADD, ULA_M_ARITH, 1'b0, 16'h0000, 1'b1, 1'b1);
    endtask

    task automatic test_backpressure;
        start_op(16'h1111, 16'h2222, ULA_S_ADD, ULA_M_ARITH, 1'b1);
        tick;
        tick;
        in_a = 16'h5555; in_b = 16'hAAAA; in_s = ULA_S_XOR; in_m = ULA_M_LOGIC; in_c_in = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            total_cnt++;
            if (res_valid !== 1'b1 || in_ready !== 1'b0 || res_f !== 16'h3334 ||
                res_c_out !== 1'b0 || res_a_eq_b !== 1'b0)
                $display("FAIL bp_hold: v=%b rdy=%b f=%h c=%b eq=%b required 1 0 3334 0 0",
                         res_valid, in_ready, res_f, res_c_out, res_a_eq_b);
            else pass_cnt++;
            tick;
        end
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || res_valid !== 1'b0 || res_f !== 16'h3334)
            $display("FAIL bp_to_idle: busy=%b rdy=%b v=%b f=%h required 0 1 0 3334",
                     busy, in_ready, res_valid, res_f);
        else pass_cnt++;
        tick;
        in_valid = 1'b0;
        total_cnt++;
        if (busy !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL bp_accept: busy=%b rdy=%b required 1 0", busy, in_ready);
        else pass_cnt++;
        tick;
        tick;
        total_cnt++;
        if (res_valid !== 1'b1 || res_f !== 16'hFFFF || res_c_out !== 1'b0 || res_a_eq_b !== 1'b0)
            $display("FAIL bp_second: v=%b f=%h c=%b eq=%b required 1 ffff 0 0",
                     res_valid, res_f, res_c_out, res_a_eq_b);
        else pass_cnt++;
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        int seen;
        start_op(16'hFFFF, 16'h0001, ULA_S_ADD, ULA_M_ARITH, 1'b0);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || in_ready !== 1'b1 || res_f !== 16'h0000 ||
            res_a_eq_b !== 1'b1 || res_c_out !== 1'b0 || alu_a !== 8'h00)
            $display("FAIL midrst_state: busy=%b v=%b rdy=%b f=%h eq=%b c=%b a=%h required 0 0 1 0000 1 0 00",
                     busy, res_valid, in_ready, res_f, res_a_eq_b, res_c_out, alu_a);
        else pass_cnt++;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (res_valid) seen++;
            tick;
        end
        total_cnt++;
        if (seen != 0) $display("FAIL midrst_no_valid: pulses=%0d required 0", seen);
        else pass_cnt++;
        do_op("midrst_next", 16'hF0F0, 16'h0F0F, ULA_S_XOR, ULA_M_LOGIC, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [15:0] qa [20];
        logic [15:0] qb [20];
        logic [3:0]  qs [20];
        logic        qm [20];
        logic        qc [20];
        logic [15:0] ef [20];
        logic        ec [20];
        logic        ee [20];
        logic [16:0] sum;
        int i_in, i_out, cyc, last_acc;
        logic will_accept;
        for (int i = 0; i < 20; i++) begin
            qa[i] = 16'($urandom);
            qb[i] = (i % 5 == 0) ? qa[i] : 16'($urandom);
            qc[i] = 1'($urandom);
            case ($urandom_range(3, 0))
                0: begin qs[i] = ULA_S_XOR; qm[i] = ULA_M_LOGIC; end
                1: begin qs[i] = ULA_S_AND; qm[i] = ULA_M_LOGIC; end
                2: begin qs[i] = ULA_S_OR;  qm[i] = ULA_M_LOGIC; end
                default: begin qs[i] = ULA_S_ADD; qm[i] = ULA_M_ARITH; end
            endcase
            ec[i] = 1'b0;
            ee[i] = (qa[i] == qb[i]);
            case (qs[i])
                ULA_S_XOR: ef[i] = qa[i] ^ qb[i];
                ULA_S_AND: ef[i] = qa[i] & qb[i];
                ULA_S_OR:  ef[i] = qa[i] | qb[i];
                default: begin
                    sum   = {1'b0, qa[i]} + {1'b0, qb[i]} + {16'b0, qc[i]};
                    ef[i] = sum[15:0];
                    ec[i] = sum[16];
                end
            endcase
        end
        i_in = 0; i_out = 0; last_acc = -1;
        in_a = qa[0]; in_b = qb[0]; in_s = qs[0]; in_m = qm[0]; in_c_in = qc[0];
        in_valid = 1'b1;
        res_ready = 1'b1;
        for (cyc = 0; cyc < 200 && i_out < 20; cyc++) begin
            will_accept = in_ready && in_valid;
            if (res_valid) begin
                total_cnt++;
                if (res_f !== ef[i_out] || res_c_out !== ec[i_out] || res_a_eq_b !== ee[i_out])
                    $display("FAIL b2b_result[%0d]: f=%h c=%b eq=%b required f=%h c=%b eq=%b",
                             i_out, res_f, res_c_out, res_a_eq_b, ef[i_out], ec[i_out], ee[i_out]);
                else pass_cnt++;
                i_out++;
            end
            tick;
            if (will_accept) begin
                if (last_acc >= 0) begin
                    total_cnt++;
                    if (cyc - last_acc != 4)
                        $display("FAIL b2b_spacing[%0d]: gap=%0d required 4", i_in, cyc - last_acc);
                    else pass_cnt++;
                end
                last_acc = cyc;
                i_in++;
                if (i_in < 20) begin
                    in_a = qa[i_in]; in_b = qb[i_in]; in_s = qs[i_in];
                    in_m = qm[i_in]; in_c_in = qc[i_in];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        if (i_out < 20) begin
            total_cnt++;
            $display("FAIL b2b_timeout: results=%0d required 20", i_out);
        end
        res_ready = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset;
        test_logic;
        test_carry;
        test_backpressure;
        test_reset_mid;
        test_back_to_back;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
